// File: rtl/date_set_ctrl.sv
// Front-panel date editor: captures the running date, edits day/month/year, then strobes date_ow.
// Define DATE_SET_FULL_LEAP_EN for the full Gregorian leap rule; by default year[1:0]==0 is leap.
module date_set_ctrl #(
  parameter int          OW_CYCLES      = 2,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [11:0] RESET_YEAR     = 12'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [20:0] date_cur,
  output logic [20:0] date_in,
  output logic        date_ow,
  output logic        editing,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {IDLE, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT} state_t;

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     OW_LAST = 4'(OW_CYCLES);

  function automatic logic is_leap(input logic [11:0] y);
`ifdef DATE_SET_FULL_LEAP_EN
    return (y[1:0] == 2'b00) && (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
`else
    return (y[1:0] == 2'b00);
`endif
  endfunction

  function automatic logic [4:0] max_day(input logic [3:0] m, input logic [11:0] y);
    case (m)
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  // Buttons packed as {mode, up, down}: two sync flops, then a rising-edge detect.
  logic [2:0] btn_raw, sync1_reg, sync2_reg, prev_reg, evt;
  assign btn_raw = {btn_mode, btn_up, btn_down};
  assign evt     = sync2_reg & ~prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  logic evt_mode, evt_up, evt_step;
  assign evt_mode = evt[2];
  assign evt_up   = evt[1];
  assign evt_step = evt[1] ^ evt[0];

  state_t         state_reg;
  logic [4:0]     day_reg, saved_day_reg;
  logic [3:0]     month_reg, saved_month_reg;
  logic [11:0]    year_reg, saved_year_reg;
  logic [TW-1:0]  to_cnt_reg;
  logic [3:0]     ow_cnt_reg;
  logic           date_ow_reg, editing_reg;
  logic [1:0]     field_sel_reg;

  // Candidate values for a single up/down step of each field, with the day clamped.
  logic [4:0]  md_cur, day_step, md_month, day_clamp_m, md_year, day_clamp_y;
  logic [3:0]  month_step;
  logic [11:0] year_step;

  assign md_cur      = max_day(month_reg, year_reg);
  assign day_step    = evt_up ? ((day_reg >= md_cur) ? 5'd1 : day_reg + 5'd1)
                              : ((day_reg <= 5'd1) ? md_cur : day_reg - 5'd1);
  assign month_step  = evt_up ? ((month_reg >= 4'd12) ? 4'd1 : month_reg + 4'd1)
                              : ((month_reg <= 4'd1) ? 4'd12 : month_reg - 4'd1);
  assign md_month    = max_day(month_step, year_reg);
  assign day_clamp_m = (day_reg > md_month) ? md_month : day_reg;
  assign year_step   = evt_up ? year_reg + 12'd1 : year_reg - 12'd1;
  assign md_year     = max_day(month_reg, year_step);
  assign day_clamp_y = (day_reg > md_year) ? md_year : day_reg;

  // Sanitized capture of the running date.
  logic [4:0]  cap_day_raw, md_cap, cap_day;
  logic [3:0]  cap_month;
  logic [11:0] cap_year;

  assign cap_month   = (date_cur[15:12] == 4'd0 || date_cur[15:12] > 4'd12) ? 4'd1 : date_cur[15:12];
  assign cap_year    = date_cur[11:0];
  assign md_cap      = max_day(cap_month, cap_year);
  assign cap_day_raw = (date_cur[20:16] == 5'd0) ? 5'd1 : date_cur[20:16];
  assign cap_day     = (cap_day_raw > md_cap) ? md_cap : cap_day_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      day_reg         <= 5'd1;
      month_reg       <= 4'd1;
      year_reg        <= RESET_YEAR;
      saved_day_reg   <= 5'd1;
      saved_month_reg <= 4'd1;
      saved_year_reg  <= RESET_YEAR;
      to_cnt_reg      <= '0;
      ow_cnt_reg      <= '0;
      date_ow_reg     <= 1'b0;
      editing_reg     <= 1'b0;
      field_sel_reg   <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          date_ow_reg <= 1'b0;
          if (evt_mode) begin
            day_reg         <= cap_day;
            month_reg       <= cap_month;
            year_reg        <= cap_year;
            saved_day_reg   <= cap_day;
            saved_month_reg <= cap_month;
            saved_year_reg  <= cap_year;
            to_cnt_reg      <= '0;
            state_reg       <= EDIT_DAY;
            editing_reg     <= 1'b1;
            field_sel_reg   <= 2'd1;
          end
        end

        EDIT_DAY, EDIT_MONTH, EDIT_YEAR: begin
          if (evt_mode) begin
            to_cnt_reg <= '0;
            case (state_reg)
              EDIT_DAY: begin
                state_reg     <= EDIT_MONTH;
                field_sel_reg <= 2'd2;
              end
              EDIT_MONTH: begin
                state_reg     <= EDIT_YEAR;
                field_sel_reg <= 2'd3;
              end
              default: begin
                state_reg     <= COMMIT;
                editing_reg   <= 1'b0;
                field_sel_reg <= 2'd0;
                ow_cnt_reg    <= '0;
              end
            endcase
          end else if (evt_step) begin
            to_cnt_reg <= '0;
            case (state_reg)
              EDIT_DAY: day_reg <= day_step;
              EDIT_MONTH: begin
                month_reg <= month_step;
                day_reg   <= day_clamp_m;
              end
              default: begin
                year_reg <= year_step;
                day_reg  <= day_clamp_y;
              end
            endcase
          end else if (to_cnt_reg == TO_LAST) begin
            // Abandoned edit: put back what was captured and drop out without a write.
            day_reg       <= saved_day_reg;
            month_reg     <= saved_month_reg;
            year_reg      <= saved_year_reg;
            to_cnt_reg    <= '0;
            state_reg     <= IDLE;
            editing_reg   <= 1'b0;
            field_sel_reg <= 2'd0;
          end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
          end
        end

        COMMIT: begin
          if (ow_cnt_reg < OW_LAST) begin
            date_ow_reg <= 1'b1;
            ow_cnt_reg  <= ow_cnt_reg + 4'd1;
          end else begin
            date_ow_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          date_ow_reg   <= 1'b0;
          editing_reg   <= 1'b0;
          field_sel_reg <= 2'd0;
        end
      endcase
    end
  end

  assign date_in   = {day_reg, month_reg, year_reg};
  assign date_ow   = date_ow_reg;
  assign editing   = editing_reg;
  assign field_sel = field_sel_reg;

endmodule

// File: doc/date_set_ctrl.md
Name: date_set_ctrl

Overview:
- Button-driven date editor that drives the date-overwrite interface of the date counter.
- Loads the running date, lets the user edit day, then month, then year, validates the result, and writes the 21-bit date word.
- Asserts the asynchronous overwrite strobe for a fixed number of cycles.
- Sits between the debounced front-panel buttons and the date counter.

Parameters:
OW_CYCLES, 2, cycles date_ow is held high during commit (1..15)
TIMEOUT_CYCLES, 1000000, idle cycles in any edit state before the edit is abandoned without write
RESET_YEAR, 2000, year field value after reset (12-bit)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  debounced mode button, level, asynchronous to clk
btn_up  input  1  debounced increment button, level
btn_down  input  1  debounced decrement button, level
date_cur  input  21  running date {day[4:0], month[3:0], year[11:0]} from the date counter
date_in  output  21  date word to the counter's overwrite input, same format
date_ow  output  1  overwrite strobe, active high
editing  output  1  high in any EDIT state
field_sel  output  2  0 = none, 1 = day, 2 = month, 3 = year

Behaviour:
- Reset (rst_n low, async):
  - state IDLE, date_ow 0, editing 0, field_sel 0.
  - edit regs day 1, month 1, year RESET_YEAR; timeout counter 0.
- Buttons: each goes through a 2-flop synchronizer, then rising-edge detect. The action takes effect on the 3rd rising clk edge after the raw input rises. Holding a button produces one event only.
- Event priority: mode > up/down. Up and down in the same cycle: both ignored.
- States: IDLE -> EDIT_DAY -> EDIT_MONTH -> EDIT_YEAR -> COMMIT -> IDLE.
- IDLE:
  - Up/down ignored.
  - Mode captures date_cur into the edit regs and enters EDIT_DAY.
  - Capture sanitizes: day 0 -> 1; month 0 or >12 -> 1; day > maxday(month, year) -> maxday.
- EDIT_x: mode advances to the next state. Up/down change only the selected field:
  - day: 1..maxday, wrapping in both directions.
  - month: 1..12, wrapping.
  - year: modulo 4096 (4095+1 = 0, 0-1 = 4095).
- Clamping: after any month or year change, day is clamped to maxday in the same cycle the field updates.
- maxday:
  - Month 2: 29 if leap, else 28.
  - Months 4, 6, 9, 11: 30.
  - All other months: 31.
- COMMIT:
  - date_ow is high for exactly OW_CYCLES consecutive cycles, starting the cycle after entry.
  - date_in is stable for the whole strobe plus one cycle after.
  - Returns to IDLE; all buttons ignored during COMMIT.
- date_in = {day, month, year} edit regs at all times; it keeps the last committed value in IDLE.
- Timeout:
  - The counter increments each cycle in EDIT states and clears on any accepted button event.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, no date_ow, edit regs restored to the value captured on entry.
- editing and field_sel are registered and reflect the current state.
- Reset mid-commit: date_ow drops asynchronously and no further strobe occurs.

Optional Feature:
DATE_SET_FULL_LEAP_EN
- Defined: full Gregorian leap rule. Leap if year % 4 == 0 and (year % 100 != 0 or year % 400 == 0); year is treated as an absolute year.
- Undefined: leap if year[1:0] == 0 only, matching the date counter's rule.
- Affects maxday, clamping and capture sanitization only.

Test Plan:
- Reset, date_cur = {5'd15, 4'd6, 12'd2024}; mode x4, no up/down -> date_in = {15, 6, 2024}; date_ow high exactly 2 cycles; return to IDLE.
- Capture {31, 1, 2023}, mode, mode (EDIT_MONTH), up -> month 2, day clamped to 28; year 2024 -> day stays 28; year 2024 with day set to 29 first -> 29 kept.
- EDIT_DAY with day 1, month 4, down -> 30; up -> 1. EDIT_YEAR 4095 up -> 0; 0 down -> 4095.
- Up and down rising in the same cycle -> no change. Mode and up rising in the same cycle -> field advances, value unchanged.
- TIMEOUT_CYCLES = 100: enter edit, change day, wait 100 cycles -> IDLE, date_ow never high, date_in equals captured value.
- Year 1900, February, day 29 path: with macro defined, day clamps to 28; without macro, 29 is allowed. Also assert rst_n low during COMMIT -> date_ow 0 immediately.
